a1_sweep_checker: RTL and testbench
===================================

Name: a1_sweep_checker

Overview:
Self-checking response side for the 3-input combinational function block A1 (1-bit output f).
- After a start pulse, drives every input vector 0..2^N_IN-1 in ascending order.
- Waits a programmable settle time for each vector, then samples the DUT's 1-bit response and compares it against a truth-table parameter.
- Reports pass/fail, a mismatch count and the first failing vector.
- Runs on-chip, so sweeps repeat in hardware without a simulation bench.

Parameters:
- N_IN, 3, width of the stimulus vector; number of vectors = 2^N_IN.
- EXPECT, 8'b1110_1000, expected truth table; bit k = expected response for vector k. Width = 2^N_IN.
- SETTLE, 2, cycles each vector is held before sampling. Legal values: 1 or more.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin a sweep.
- stim  out  N_IN  vector driven to the DUT input i.
- resp  in  1  DUT output f.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high once a sweep completes; held until the next accepted start.
- pass  out  1  done AND err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors in the current/last sweep.
- fail_valid  out  1  at least one mismatch has been recorded this sweep.
- first_fail_idx  out  N_IN  index of the first mismatching vector; meaningful only when fail_valid=1.

Behaviour:
- Reset (rst=1 at a clock edge): all outputs go to 0 and state goes to IDLE. Reset mid-sweep aborts immediately with no partial result kept.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1: go to SETTLE; stim<=0, settle counter<=0; clear err_count, fail_valid and first_fail_idx; busy<=1.
- SETTLE: counter increments each cycle. When counter==SETTLE-1, go to SAMPLE. stim is held stable.
- SAMPLE (exactly one cycle): resp is sampled at the edge leaving this state.
  - On mismatch (resp != EXPECT[stim]): err_count<=err_count+1.
  - If fail_valid was 0, also set fail_valid<=1 and first_fail_idx<=stim.
  - If stim==2^N_IN-1: go to DONE; busy<=0, done<=1.
  - Otherwise: stim<=stim+1, counter<=0, return to SETTLE.
- Timing: each vector occupies SETTLE+1 cycles.
  - Vector v is sampled at edge E0+(v+1)*(SETTLE+1), where E0 is the edge that accepted start.
  - done rises after edge E0+2^N_IN*(SETTLE+1); with defaults that is E0+24.
- DONE:
  - Outputs hold; stim holds 2^N_IN-1.
  - start=1 behaves exactly as in IDLE: results cleared, new sweep begins, done<=0 on the same edge.
- start while busy=1 is ignored and has no effect on the sweep.
- rst and start asserted on the same edge: rst wins.
- err_count does not wrap; its maximum value 2^N_IN fits in N_IN+1 bits.
- pass is combinational from done and err_count: 0 during a sweep, 0 in IDLE.
- resp is treated as synchronous to clk. The DUT is combinational and must settle within SETTLE cycles.

Test Plan:
- Correct DUT model (majority function = EXPECT), start pulse at E0 -> stim steps 0..7, each held 3 cycles. done=1 and pass=1 from edge E0+24, err_count=0, fail_valid=0.
- Inverted DUT (f = not majority) -> done at E0+24, err_count=8, fail_valid=1, first_fail_idx=0, pass=0.
- DUT with a single fault at vector 5 (f=0 instead of 1) -> err_count=1, first_fail_idx=5, pass=0. A second fault injected at 6 -> err_count=2, first_fail_idx still 5.
- start re-pulsed at E0+7 while busy -> ignored; done still rises at E0+24, and the sample schedule is unchanged.
- rst asserted at E0+10 -> next cycle all outputs 0, state IDLE. New start at E0+15 -> full sweep, done at E0+15+24 with correct results.
- Restart from DONE after a failing sweep, with DUT corrected -> on the start edge done=0, err_count=0, fail_valid=0. The sweep then ends with pass=1.

Source files
------------

// File: rtl/a1_sweep_checker.sv
// a1_sweep_checker: on-chip exhaustive checker for a combinational block with N_IN inputs
// and one output. After an accepted start it walks stim through 0..2^N_IN-1, holds each
// vector SETTLE cycles, then spends one cycle sampling resp against the EXPECT truth table.
//
// Ports:
//   clk            system clock, all state changes on rising edge
//   rst            synchronous active-high reset
//   start          single-cycle sweep request (ignored while busy)
//   stim           vector driven to the block under test
//   resp           block under test output
//   busy           sweep in progress
//   done           sweep complete, held until the next accepted start
//   pass           done and no mismatches
//   err_count      mismatching vectors in the current/last sweep
//   fail_valid     at least one mismatch recorded this sweep
//   first_fail_idx first mismatching vector (valid when fail_valid)
module a1_sweep_checker #(
  parameter int unsigned        N_IN   = 3,
  parameter logic [2**N_IN-1:0] EXPECT = 8'b1110_1000,
  parameter int unsigned        SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int unsigned       CntW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0]   LastVec    = '1;

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]     err_q, err_d;
  logic              fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]   first_q, first_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mismatch;

  assign mismatch = (resp != EXPECT[stim_q]);

  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_d      = first_q;
    busy_d       = busy_q;
    done_d       = done_q;
    unique case (state_q)
      // DONE accepts a restart exactly like IDLE; results are cleared on the start edge.
      StIdle, StDone: begin
        if (start) begin
          state_d      = StSettle;
          stim_d       = '0;
          cnt_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_d      = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (mismatch) begin
          err_d = err_q + (N_IN + 1)'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_d      = stim_q;
          end
        end
        if (stim_q == LastVec) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = StSettle;
          stim_d  = stim_q + N_IN'(1);
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      stim_q       <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_q      <= first_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_idx = first_q;
  assign pass           = done_q && (err_q == '0);

endmodule

// File: tb/tb_a1_sweep_checker.sv
// Directed bench for a1_sweep_checker with a behavioural majority-function block whose
// response can be corrupted per vector through flip_mask.
module tb_a1_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] stim;
  logic       resp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [2:0] first_fail_idx;
  logic [7:0] flip_mask = 8'h00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Block under test model: 3-input majority, optionally inverted per vector.
  assign resp = ((stim[0] & stim[1]) | (stim[0] & stim[2]) | (stim[1] & stim[2]))
                ^ flip_mask[stim];

  a1_sweep_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stim           (stim),
    .resp           (resp),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .fail_valid     (fail_valid),
    .first_fail_idx (first_fail_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1ns after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise start before the next edge (E0) and drop it 1ns after E0.
  task automatic pulse_start();
    start = 1'b1;
    edges(1);
    start = 1'b0;
  endtask

  // From 1ns after E0: check done timing and final results.
  task automatic finish_sweep(input string tag, input logic [3:0] errs, input logic fv,
                              input logic [2:0] first, input logic ok);
    edges(23);
    check({tag, "_done_e23"}, done, 1'b0);
    check({tag, "_busy_e23"}, busy, 1'b1);
    edges(1);
    check({tag, "_done_e24"}, done, 1'b1);
    check({tag, "_busy_e24"}, busy, 1'b0);
    check({tag, "_err"}, err_count, errs);
    check({tag, "_fv"}, fail_valid, fv);
    if (fv) check({tag, "_first"}, first_fail_idx, first);
    check({tag, "_pass"}, pass, ok);
    check({tag, "_stim_hold"}, stim, 3'd7);
  endtask

  initial begin
    // Reset state
    edges(2);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err", err_count, 4'd0);
    check("rst_fv", fail_valid, 1'b0);
    check("rst_stim", stim, 3'd0);
    rst = 1'b0;
    edges(2);
    check("idle_busy", busy, 1'b0);

    // Correct block: stim steps every 3 cycles.
    pulse_start();
    check("ok_busy_e0", busy, 1'b1);
    check("ok_stim_e0", stim, 3'd0);
    check("ok_pass_run", pass, 1'b0);
    edges(2);
    check("ok_stim_e2", stim, 3'd0);
    edges(1);
    check("ok_stim_e3", stim, 3'd1);
    edges(12);
    check("ok_stim_e15", stim, 3'd5);
    edges(8);
    check("ok_done_e23", done, 1'b0);
    edges(1);
    check("ok_done_e24", done, 1'b1);
    check("ok_pass", pass, 1'b1);
    check("ok_err", err_count, 4'd0);
    check("ok_fv", fail_valid, 1'b0);
    edges(3);
    check("ok_done_hold", done, 1'b1);
    check("ok_stim_hold", stim, 3'd7);

    // Inverted block: every vector fails, err_count reaches 8 without wrapping.
    flip_mask = 8'hFF;
    pulse_start();
    check("inv_done_clr", done, 1'b0);
    finish_sweep("inv", 4'd8, 1'b1, 3'd0, 1'b0);

    // Restart from DONE with block corrected: results cleared on the start edge.
    flip_mask = 8'h00;
    pulse_start();
    check("rs_done_clr", done, 1'b0);
    check("rs_err_clr", err_count, 4'd0);
    check("rs_fv_clr", fail_valid, 1'b0);
    check("rs_busy", busy, 1'b1);
    finish_sweep("rs", 4'd0, 1'b0, 3'd0, 1'b1);

    // Single fault at vector 5.
    flip_mask = 8'b0010_0000;
    pulse_start();
    finish_sweep("f5", 4'd1, 1'b1, 3'd5, 1'b0);

    // Faults at 5 and 6: first index stays 5.
    flip_mask = 8'b0110_0000;
    pulse_start();
    finish_sweep("f56", 4'd2, 1'b1, 3'd5, 1'b0);

    // start re-pulsed at E0+7 while busy is ignored.
    flip_mask = 8'h00;
    pulse_start();
    edges(6);
    start = 1'b1;
    edges(1);
    start = 1'b0;
    check("ign_stim_e7", stim, 3'd2);
    edges(2);
    check("ign_stim_e9", stim, 3'd3);
    edges(14);
    check("ign_done_e23", done, 1'b0);
    edges(1);
    check("ign_done_e24", done, 1'b1);
    check("ign_pass", pass, 1'b1);

    // Reset at E0+10 aborts; new start at E0+15 runs a full sweep.
    flip_mask = 8'b0000_0001;
    pulse_start();
    edges(9);
    rst = 1'b1;
    start = 1'b1;
    edges(1);
    rst = 1'b0;
    start = 1'b0;
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    check("ab_err", err_count, 4'd0);
    check("ab_fv", fail_valid, 1'b0);
    check("ab_stim", stim, 3'd0);
    edges(3);
    check("ab_idle", busy, 1'b0);
    flip_mask = 8'h00;
    edges(1);
    pulse_start();
    finish_sweep("ab_re", 4'd0, 1'b0, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
